// File: rtl/spi_pkg.sv
// Shared constants, state encoding and address helper for the SPI slave
// and its register file.
package spi_pkg;

  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 8;
  localparam int READ_BIT = 7;
  localparam int ADDR_MSB = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CMD   = 2'd1,
    S_WRITE = 2'd2,
    S_READ  = 2'd3
  } state_e;

  // 6-bit address increment; wraps 63 -> 0 naturally.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + 6'd1;
  endfunction

endpackage

// File: rtl/dram64x8.sv
// 64x8 distributed register file: port A synchronous write with
// combinational read, port B combinational read. Contents are never reset.
module dram64x8
  import spi_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_a_we,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_wdata,
  output logic [DATA_W-1:0] o_a_rdata,
  input  logic [ADDR_W-1:0] i_b_addr,
  output logic [DATA_W-1:0] o_b_rdata
);

  logic [DATA_W-1:0] mem_q [64];

  // Write port; reads below see the old word during a same-cycle write.
  always_ff @(posedge i_clk) begin
    if (i_a_we) begin
      mem_q[i_a_addr] <= i_a_wdata;
    end
  end

  assign o_a_rdata = mem_q[i_a_addr];
  assign o_b_rdata = mem_q[i_b_addr];

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI slave giving an SPI master byte-wise read/write access to a
// 64x8 register file, oversampled entirely in the i_clk domain.
module spi_slave
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_spi_en,
  input  logic              i_spi_clk,
  input  logic              i_spi_mosi,
  output logic              o_spi_miso,
  input  logic [ADDR_W-1:0] i_reg_addr,
  output logic [DATA_W-1:0] o_reg_data,
  output logic              o_wr_stb,
  output logic              o_done
);

  logic [SYNC_STAGES-1:0] en_sync_q, en_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] valid_q, valid_d;

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_in_q, shift_in_d;
  logic [DATA_W-1:0] shift_out_q, shift_out_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              armed_q, armed_d;
  logic              miso_q, miso_d;
  logic              wr_stb_q, wr_stb_d;
  logic              done_q, done_d;

  logic              en_new_s, en_old_s;
  logic              en_rise_s, en_fall_s;
  logic              sclk_rise_s, sclk_fall_s;
  logic              mosi_s;
  logic              armed_now_s;
  logic [DATA_W-1:0] byte_s;
  logic [ADDR_W-1:0] a_addr_s;
  logic [DATA_W-1:0] a_rdata_s;
  logic              a_we_s;

  // Synchronizer shift chains plus a fill marker tracking which stages hold real samples.
  always_comb begin
    en_sync_d   = {en_sync_q[SYNC_STAGES-2:0], i_spi_en};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], i_spi_clk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_spi_mosi};
    valid_d     = {valid_q[SYNC_STAGES-2:0], 1'b1};
  end

  // Edge detection; en must be seen low after reset before a rise can open a frame.
  always_comb begin
    en_new_s    = en_sync_q[SYNC_STAGES-2];
    en_old_s    = en_sync_q[SYNC_STAGES-1];
    armed_now_s = armed_q | (valid_q[SYNC_STAGES-1] & ~en_old_s);
    armed_d     = armed_now_s;
    en_rise_s   = en_new_s & ~en_old_s & armed_now_s;
    en_fall_s   = ~en_new_s & en_old_s & valid_q[SYNC_STAGES-1];
    sclk_rise_s = sclk_sync_q[SYNC_STAGES-2] & ~sclk_sync_q[SYNC_STAGES-1];
    sclk_fall_s = ~sclk_sync_q[SYNC_STAGES-2] & sclk_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    byte_s      = {shift_in_q[DATA_W-2:0], mosi_s};
  end

  // Frame FSM and datapath next-state.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    wr_data_d   = wr_data_q;
    wr_stb_d    = 1'b0;
    done_d      = 1'b0;
    a_addr_s    = addr_q;
    if (wr_stb_q) begin
      addr_d = addr_inc(addr_q);
    end else begin
      addr_d = addr_q;
    end

    if (en_fall_s) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en_rise_s) begin
            state_d     = S_CMD;
            bit_cnt_d   = 3'd0;
            shift_in_d  = {DATA_W{1'b0}};
            shift_out_d = {DATA_W{1'b0}};
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CMD: begin
          if (sclk_rise_s) begin
            shift_in_d = byte_s;
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              addr_d   = byte_s[ADDR_MSB:0];
              a_addr_s = byte_s[ADDR_MSB:0];
              if (byte_s[READ_BIT]) begin
                state_d     = S_READ;
                shift_out_d = a_rdata_s;
              end else begin
                state_d = S_WRITE;
              end
            end else begin
              state_d = S_CMD;
            end
          end else begin
            state_d = S_CMD;
          end
        end
        S_WRITE: begin
          if (sclk_rise_s) begin
            shift_in_d = byte_s;
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              wr_stb_d  = 1'b1;
              wr_data_d = byte_s;
            end else begin
              wr_stb_d = 1'b0;
            end
          end else begin
            state_d = S_WRITE;
          end
        end
        S_READ: begin
          if (sclk_rise_s) begin
            shift_in_d = byte_s;
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              a_addr_s    = addr_inc(addr_q);
              addr_d      = addr_inc(addr_q);
              shift_out_d = a_rdata_s;
            end else begin
              shift_out_d = shift_out_q;
            end
          // The fall right after a byte's 8th rise must keep the freshly loaded MSB.
          end else if (sclk_fall_s && (bit_cnt_q != 3'd0)) begin
            shift_out_d = {shift_out_q[DATA_W-2:0], 1'b0};
          end else begin
            state_d = S_READ;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    if (state_d == S_READ) begin
      miso_d = shift_out_d[DATA_W-1];
    end else begin
      miso_d = 1'b0;
    end
  end

  assign a_we_s = wr_stb_q & i_rst_n;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      en_sync_q   <= {SYNC_STAGES{1'b0}};
      sclk_sync_q <= {SYNC_STAGES{1'b0}};
      mosi_sync_q <= {SYNC_STAGES{1'b0}};
      valid_q     <= {SYNC_STAGES{1'b0}};
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_in_q  <= {DATA_W{1'b0}};
      shift_out_q <= {DATA_W{1'b0}};
      wr_data_q   <= {DATA_W{1'b0}};
      addr_q      <= {ADDR_W{1'b0}};
      armed_q     <= 1'b0;
      miso_q      <= 1'b0;
      wr_stb_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      en_sync_q   <= en_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      valid_q     <= valid_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      wr_data_q   <= wr_data_d;
      addr_q      <= addr_d;
      armed_q     <= armed_d;
      miso_q      <= miso_d;
      wr_stb_q    <= wr_stb_d;
      done_q      <= done_d;
    end
  end

  dram64x8 u_regfile (
    .i_clk     (i_clk),
    .i_a_we    (a_we_s),
    .i_a_addr  (a_addr_s),
    .i_a_wdata (wr_data_q),
    .o_a_rdata (a_rdata_s),
    .i_b_addr  (i_reg_addr),
    .o_b_rdata (o_reg_data)
  );

  assign o_spi_miso = miso_q;
  assign o_wr_stb   = wr_stb_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a bit-banged SPI master drives frames and
// a plain array of the register file predicts every read-back value.
module tb_spi_slave;

  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       i_rst_n, i_spi_en, i_spi_clk, i_spi_mosi;
  logic       o_spi_miso, o_wr_stb, o_done;
  logic [5:0] i_reg_addr;
  logic [7:0] o_reg_data;

  always #5 clk = ~clk;

  spi_slave #(.SYNC_STAGES(SS)) dut (
    .i_clk      (clk),
    .i_rst_n    (i_rst_n),
    .i_spi_en   (i_spi_en),
    .i_spi_clk  (i_spi_clk),
    .i_spi_mosi (i_spi_mosi),
    .o_spi_miso (o_spi_miso),
    .i_reg_addr (i_reg_addr),
    .o_reg_data (o_reg_data),
    .o_wr_stb   (o_wr_stb),
    .o_done     (o_done)
  );

  int         passed = 0;
  int         total  = 0;
  int         wr_cnt = 0;
  int         done_cnt = 0;
  int         half = 4;
  int         rst_bit = -1;
  logic       cmd_miso_bad;
  logic [7:0] model [64];
  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];
  logic [7:0] data_q [$];

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (o_wr_stb === 1'b1) wr_cnt++;
    if (o_done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Bit-bang one mode-0 frame of nbits from tx_q; bytes seen on MISO go to rx_q.
  task automatic frame(input int nbits);
    logic [7:0] cur, txb;
    rx_q = {};
    cur = 8'h00;
    cmd_miso_bad = 1'b0;
    wr_cnt = 0;
    done_cnt = 0;
    @(negedge clk);
    i_spi_en = 1'b1;
    repeat (half) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      if (b == rst_bit) begin
        i_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        i_rst_n = 1'b1;
      end
      txb = tx_q[b / 8];
      i_spi_mosi = txb[7 - (b % 8)];
      repeat (half) @(negedge clk);
      if (b < 8 && o_spi_miso !== 1'b0) cmd_miso_bad = 1'b1;
      cur = {cur[6:0], o_spi_miso};
      i_spi_clk = 1'b1;
      if (b % 8 == 7) rx_q.push_back(cur);
      repeat (half) @(negedge clk);
      i_spi_clk = 1'b0;
    end
    repeat (half) @(negedge clk);
    i_spi_en = 1'b0;
    i_spi_mosi = 1'b0;
    repeat (half + SS + 4) @(negedge clk);
  endtask

  task automatic do_write(input logic [5:0] a, input logic b6, input string tag);
    tx_q = {};
    tx_q.push_back({1'b0, b6, a});
    foreach (data_q[i]) tx_q.push_back(data_q[i]);
    frame(8 * tx_q.size());
    foreach (data_q[i]) model[(int'(a) + i) % 64] = data_q[i];
    chk({tag, " wr_stb count"}, wr_cnt, data_q.size());
    chk({tag, " done count"}, done_cnt, 1);
  endtask

  task automatic do_read(input logic [5:0] a, input int n, input logic b6, input string tag);
    tx_q = {};
    tx_q.push_back({1'b1, b6, a});
    for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
    frame(8 * (n + 1));
    chk({tag, " miso low in cmd"}, cmd_miso_bad, 0);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s byte %0d", tag, i), rx_q[i + 1], model[(int'(a) + i) % 64]);
    chk({tag, " no wr_stb"}, wr_cnt, 0);
    chk({tag, " done count"}, done_cnt, 1);
  endtask

  task automatic check_mem(input int a, input string tag);
    i_reg_addr = 6'(a);
    #1;
    chk($sformatf("%s mem[%0d]", tag, a), o_reg_data, model[a]);
  endtask

  initial begin
    logic [5:0] ra;
    int n;
    i_rst_n = 1'b0;
    i_spi_en = 1'b0;
    i_spi_clk = 1'b0;
    i_spi_mosi = 1'b0;
    i_reg_addr = 6'd0;
    repeat (3) @(negedge clk);
    chk("reset miso", o_spi_miso, 0);
    chk("reset wr_stb", o_wr_stb, 0);
    chk("reset done", o_done, 0);
    i_rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Fill the whole register file so every later read has a known answer.
    data_q = {};
    for (int i = 0; i < 64; i++) data_q.push_back(8'($urandom));
    do_write(6'd0, 1'b0, "fill");
    for (int i = 0; i < 64; i++) check_mem(i, "fill");

    data_q = {8'hA1, 8'hB2, 8'hC3};
    do_write(6'd5, 1'b0, "write5");
    i_reg_addr = 6'd6;
    #1;
    chk("write5 const B2", o_reg_data, 8'hB2);
    do_read(6'd5, 3, 1'b0, "read5");
    chk("read5 const A1", rx_q[1], 8'hA1);
    chk("read5 const C3", rx_q[3], 8'hC3);

    data_q = {8'h11, 8'h22};
    do_write(6'd63, 1'b0, "wrapw");
    check_mem(63, "wrapw");
    check_mem(0, "wrapw");
    do_read(6'd63, 2, 1'b0, "wrapr");

    data_q = {};
    do_write(6'd9, 1'b1, "cmdonly_w");
    do_read(6'd12, 0, 1'b0, "cmdonly_r");

    // Abort mid-byte: only the completed 0x55 may land.
    tx_q = {8'h10, 8'h55, 8'h66};
    frame(20);
    model[16] = 8'h55;
    chk("abort wr_stb count", wr_cnt, 1);
    chk("abort done count", done_cnt, 1);
    check_mem(16, "abort");
    check_mem(17, "abort");

    // Reset in the middle of the first payload byte; nothing in that frame may write.
    tx_q = {8'h20, 8'h77, 8'h88, 8'h44};
    rst_bit = 12;
    frame(32);
    rst_bit = -1;
    chk("rst wr_stb count", wr_cnt, 0);
    check_mem(32, "rst");
    check_mem(33, "rst");
    check_mem(34, "rst");
    data_q = {8'h99};
    do_write(6'h20, 1'b0, "after_rst");
    i_reg_addr = 6'h20;
    #1;
    chk("after_rst const 99", o_reg_data, 8'h99);

    for (int it = 0; it < 6; it++) begin
      half = $urandom_range(6, 4);
      ra = 6'($urandom);
      n = $urandom_range(4, 1);
      data_q = {};
      for (int i = 0; i < n; i++) data_q.push_back(8'($urandom));
      do_write(ra, 1'($urandom), $sformatf("rnd_w%0d", it));
      do_read(6'($urandom), $urandom_range(4, 1), 1'($urandom), $sformatf("rnd_r%0d", it));
    end
    for (int i = 0; i < 64; i++) check_mem(i, "final");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth applied to i_spi_en, i_spi_clk and i_spi_mosi (legal values 2..3).
REQ-002 SHALL have one clock and a synchronous, active-low reset, as listed below; all other ports follow them.
REQ-003 i_clk  in  1  system clock; the only clock; every flop is posedge i_clk.
REQ-004 i_rst_n  in  1  reset; synchronous, active-low.
REQ-005 i_spi_en  in  1  frame enable from the SPI master; active-high; asynchronous to i_clk.
REQ-006 i_spi_clk  in  1  SPI serial clock; mode 0 (idle low); asynchronous to i_clk.
REQ-007 i_spi_mosi  in  1  serial data, master to slave, MSB first.
REQ-008 o_spi_miso  out  1  serial data, slave to master, MSB first.
REQ-009 i_reg_addr  in  6  fabric-side read address into the register file.
REQ-010 o_reg_data  out  8  register-file contents at i_reg_addr, combinational.
REQ-011 o_wr_stb  out  1  one-cycle pulse when a byte is written into the register file.
REQ-012 o_done  out  1  one-cycle pulse when i_spi_en falls, ending a frame.

Function
REQ-013 SHALL synchronize i_spi_en, i_spi_clk and i_spi_mosi through SYNC_STAGES flops, and SHALL detect SCLK rise/fall edges from the last two synchronized stages.
REQ-014 SHALL sample MOSI on each synchronized SCLK rise and shift MISO on each SCLK fall; bit order is MSB first.
REQ-015 Correct operation SHALL require an SCLK half-period of at least SYNC_STAGES+2 i_clk cycles.
REQ-016 Frame format: byte 0 is the command, with bit7 = 1 for read and 0 for write, bit6 ignored, and bits[5:0] the start address; bytes 1..N are payload.
REQ-017 FSM states SHALL be S_IDLE, S_CMD, S_WRITE and S_READ.
REQ-018 Any state SHALL go to S_IDLE when synchronized en falls, and SHALL pulse o_done for one cycle at that point.
REQ-019 S_IDLE -> S_CMD on synchronized en rise; the bit counter and shift register SHALL be cleared.
REQ-020 S_CMD: on the 8th SCLK rise, SHALL latch the address and go to S_WRITE or S_READ according to bit7.
REQ-021 In S_READ, on that same transition, SHALL load the MISO shift register with mem[addr] and drive bit7 of it within 1 i_clk cycle, i.e. before the next SCLK rise.
REQ-022 S_WRITE: each completed byte SHALL be written to mem[addr] and SHALL pulse o_wr_stb in the cycle after the 8th rise; addr SHALL then increment.
REQ-023 S_READ: after each 8th rise, addr SHALL increment and the shift register SHALL reload with mem[addr+1] on the same cycle.
REQ-024 Address arithmetic SHALL be 6-bit and wrap from 63 to 0 in both directions.
REQ-025 o_spi_miso SHALL be 0 outside S_READ, including during the command byte.
REQ-026 If en falls mid-byte, the partial byte SHALL be discarded, with no write and no o_wr_stb.
REQ-027 An SCLK edge coincident with the en fall SHALL be ignored.
REQ-028 A frame containing only the command byte SHALL cause no write and SHALL still pulse o_done.
REQ-029 A read of an address in the same cycle it is written SHALL return the old data.

Reset
REQ-030 While i_rst_n = 0 at a posedge of i_clk, the state SHALL be S_IDLE; o_spi_miso, o_wr_stb and o_done SHALL be 0; addr, the bit counter and the shift registers SHALL be 0; all synchronizer stages SHALL be 0.
REQ-031 Register-file contents SHALL NOT be cleared by reset.
REQ-032 Reset mid-frame SHALL abort the frame without a write; the slave SHALL then resynchronize on the next en rise only, not on an en already high.

Structure
REQ-033 The command-bit positions (READ_BIT = 7, ADDR_MSB = 5), the state encodings and the address width (6) SHALL live in a shared package spi_pkg.
REQ-034 The register file SHALL be the team's existing dram64x8 instance: port A is the SPI side (write and read-ahead), port B is the fabric side (i_reg_addr/o_reg_data).
REQ-035 No other sub-modules SHALL be used; the edge detect and synchronizers are inline.

Verification
REQ-036 Write: spi_master frame {0x05, 0xA1, 0xB2, 0xC3} -> mem[5..7] = A1, B2, C3; three o_wr_stb pulses; one o_done.
REQ-037 Read-back: after REQ-036, frame {0x85} followed by 3 read bytes -> MISO returns A1, B2, C3 MSB first; no o_wr_stb.
REQ-038 Wrap: write {0x3F, 0x11, 0x22} -> mem[63] = 11, mem[0] = 22; read {0xBF}, 2 bytes -> 11, 22.
REQ-039 Abort: write {0x10, 0x55}, then drop en after 4 bits of a third byte 0x66 -> mem[0x10] = 55, mem[0x11] unchanged, o_done pulses once.
REQ-040 Reset: assert i_rst_n = 0 for 2 cycles during the payload of write {0x20, 0x77, ...} -> no further writes in that frame; a subsequent frame {0x20, 0x99} -> mem[0x20] = 99.
REQ-041 Timing margin: SCLK half-period of 4 i_clk cycles with SYNC_STAGES = 2 -> REQ-037 passes unchanged.
